// File: rtl/key_scan.sv
// Key-matrix scanner: drives columns one-cold, samples rows through a 2-flop
// synchronizer, debounces over whole frames and reports one pulse per press.
module key_scan #(
   parameter int COLS           = 4,
   parameter int ROWS           = 4,
   parameter int COL_CYCLES     = 4,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic            scan_clk,
   input  logic            reset,
   input  logic [ROWS-1:0] key_row_in,
   output logic [COLS-1:0] key_col_out,
   output logic            key_valid,
   output logic [3:0]      key_code,
   output logic            key_held
);

   localparam int NK  = COLS * ROWS;
   localparam int CLW = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int PHW = $clog2(COL_CYCLES);
   localparam int CW  = $clog2(DEBOUNCE_SCANS + 1);

   typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED} state_t;

   logic [ROWS-1:0] sync1_q, sync2_q;
   logic            run_q;
   logic [CLW-1:0]  col_q;
   logic [PHW-1:0]  phase_q;
   logic [NK-1:0]   snap_q;
   logic            frame_q;
   state_t          state_q;
   logic [3:0]      cand_q;
   logic [CW-1:0]   cnt_q, rel_q;
   logic            valid_q, held_q;
   logic [3:0]      code_q;

   logic            cls_none, cls_single;
   logic [3:0]      cls_idx;

   // run_q holds the scan at col 0/phase 0 for the first cycle out of reset so
   // every column, including the first, is driven for a full COL_CYCLES.
   assign key_col_out = run_q ? ~(COLS'(1) << col_q) : '1;
   assign key_valid   = valid_q;
   assign key_code    = code_q;
   assign key_held    = held_q;

   always_ff @(posedge scan_clk) begin
      if (!reset) begin
         sync1_q <= '1;
         sync2_q <= '1;
         run_q   <= 1'b0;
         col_q   <= '0;
         phase_q <= '0;
         snap_q  <= '0;
         frame_q <= 1'b0;
      end else begin
         sync1_q <= key_row_in;
         sync2_q <= sync1_q;
         run_q   <= 1'b1;
         frame_q <= 1'b0;
         if (run_q) begin
            if (phase_q == PHW'(COL_CYCLES - 1)) begin
               phase_q                   <= '0;
               snap_q[col_q*ROWS +: ROWS] <= ~sync2_q;
               if (col_q == CLW'(COLS - 1)) begin
                  col_q   <= '0;
                  frame_q <= 1'b1;
               end else begin
                  col_q <= col_q + 1'b1;
               end
            end else begin
               phase_q <= phase_q + 1'b1;
            end
         end
      end
   end

   // A frame is SINGLE when exactly one bit is set (power-of-two test).
   always_comb begin
      cls_none   = (snap_q == '0);
      cls_single = !cls_none && ((snap_q & (snap_q - 1'b1)) == '0);
      cls_idx    = '0;
      for (int i = 0; i < NK; i++)
         if (snap_q[i]) cls_idx = 4'(i);
   end

   always_ff @(posedge scan_clk) begin
      if (!reset) begin
         state_q <= IDLE;
         cand_q  <= '0;
         cnt_q   <= '0;
         rel_q   <= '0;
         valid_q <= 1'b0;
         held_q  <= 1'b0;
         code_q  <= '0;
      end else begin
         valid_q <= 1'b0;
         if (frame_q) begin
            case (state_q)
               IDLE: begin
                  if (cls_single) begin
                     cand_q <= cls_idx;
                     if (DEBOUNCE_SCANS == 1) begin
                        code_q  <= cls_idx;
                        valid_q <= 1'b1;
                        held_q  <= 1'b1;
                        rel_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= PRESSED;
                     end else begin
                        cnt_q   <= CW'(1);
                        state_q <= DEBOUNCE;
                     end
                  end
               end
               DEBOUNCE: begin
                  if (cls_single && cls_idx == cand_q) begin
                     if (cnt_q >= CW'(DEBOUNCE_SCANS - 1)) begin
                        code_q  <= cand_q;
                        valid_q <= 1'b1;
                        held_q  <= 1'b1;
                        rel_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= PRESSED;
                     end else begin
                        cnt_q <= cnt_q + 1'b1;
                     end
                  end else begin
                     cnt_q   <= '0;
                     state_q <= IDLE;
                  end
               end
               PRESSED: begin
                  if (cls_none) begin
                     if (rel_q >= CW'(DEBOUNCE_SCANS - 1)) begin
                        rel_q   <= '0;
                        held_q  <= 1'b0;
                        state_q <= IDLE;
                     end else begin
                        rel_q <= rel_q + 1'b1;
                     end
                  end else begin
                     rel_q <= '0;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

endmodule
